// File: rtl/transform_ctrl_pkg.sv
// Shared types and helpers for the separable 2D transform sequencer.
package transform_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHRun,
    StHDrain,
    StVRun,
    StVDrain,
    StDone
  } state_e;

  localparam logic [2:0] MIN_LOG2 = 3'd2;

  function automatic logic [2:0] clamp_size_log2(input logic [2:0] size_log2,
                                                 input logic [2:0] max_log2);
    if (size_log2 < MIN_LOG2) begin
      return MIN_LOG2;
    end else if (size_log2 > max_log2) begin
      return max_log2;
    end else begin
      return size_log2;
    end
  endfunction

endpackage

// File: rtl/ctrl_delay_line.sv
// LAT-deep enable-gated shift register that tracks issued rows through the datapath latency.
module ctrl_delay_line #(
  parameter int unsigned LAT = 2,
  parameter int unsigned W   = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  if (LAT == 0) begin : g_wire
    assign dout = din;
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, reset, en};
  end else begin : g_pipe
    logic [W-1:0] stage_q [LAT];

    // Whole stages are cleared so the delayed index also reads zero after reset.
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < LAT; i++) stage_q[i] <= '0;
      end else if (en) begin
        stage_q[0] <= din;
        for (int i = 1; i < LAT; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign dout = stage_q[LAT-1];
  end

endmodule

// File: rtl/transform_2d_seq_ctrl.sv
// Sequencer for the separable 2D transform: horizontal pass into the transpose buffer,
// latency drain, vertical pass to the output, drain, then a one-cycle done pulse.
module transform_2d_seq_ctrl
  import transform_ctrl_pkg::*;
#(
  parameter  int unsigned MAX_N = 32,
  parameter  int unsigned LAT   = 2,
  localparam int unsigned CW    = $clog2(MAX_N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [2:0]    size_log2,
  input  logic          stall,
  output logic          ready,
  output logic          busy,
  output logic          done,
  output logic          direction,
  output logic          src_sel,
  output logic [CW-1:0] row_idx,
  output logic          issue,
  output logic          buf_wr_en,
  output logic [CW-1:0] buf_wr_addr,
  output logic          out_valid,
  output logic [CW-1:0] out_idx
);

  localparam int unsigned DW        = (LAT > 0) ? $clog2(LAT + 1) : 1;
  localparam logic [2:0]  MaxLog2   = 3'($clog2(MAX_N));
  localparam logic [DW-1:0] DrainLast = DW'((LAT > 0) ? LAT - 1 : 0);

  state_e        state_q, state_d;
  logic [CW-1:0] row_q, row_d;
  logic [CW-1:0] last_q, last_d;
  logic [DW-1:0] drain_q, drain_d;
  logic [2:0]    size_clamped;

  assign size_clamped = clamp_size_log2(size_log2, MaxLog2);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      row_q   <= '0;
      last_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      last_q  <= last_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    last_d  = last_q;
    drain_d = drain_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StHRun;
          row_d   = '0;
          last_d  = CW'((32'd1 << size_clamped) - 32'd1);
        end
      end
      StHRun: begin
        if (!stall) begin
          if (row_q == last_q) begin
            row_d   = '0;
            state_d = (LAT == 0) ? StVRun : StHDrain;
          end else begin
            row_d = row_q + CW'(1);
          end
        end
      end
      StHDrain: begin
        if (!stall) begin
          if (drain_q == DrainLast) begin
            drain_d = '0;
            state_d = StVRun;
          end else begin
            drain_d = drain_q + DW'(1);
          end
        end
      end
      StVRun: begin
        if (!stall) begin
          if (row_q == last_q) begin
            row_d   = '0;
            state_d = (LAT == 0) ? StDone : StVDrain;
          end else begin
            row_d = row_q + CW'(1);
          end
        end
      end
      StVDrain: begin
        if (!stall) begin
          if (drain_q == DrainLast) begin
            drain_d = '0;
            state_d = StDone;
          end else begin
            drain_d = drain_q + DW'(1);
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ready     = 1'b0;
    done      = 1'b0;
    direction = 1'b0;
    src_sel   = 1'b0;
    issue     = 1'b0;
    unique case (state_q)
      StIdle:   ready = 1'b1;
      StHRun: begin
        direction = 1'b1;
        issue     = !stall;
      end
      StHDrain: direction = 1'b1;
      StVRun: begin
        src_sel = 1'b1;
        issue   = !stall;
      end
      StVDrain: src_sel = 1'b1;
      StDone:   done = 1'b1;
      default:  ready = 1'b0;
    endcase
    busy = !ready;
  end

  assign row_idx = row_q;

  logic [CW+1:0] dl_in, dl_out;

  assign dl_in = {issue, direction, row_idx};

  ctrl_delay_line #(
    .LAT (LAT),
    .W   (CW + 2)
  ) u_delay_line (
    .clk   (clk),
    .reset (reset),
    .en    (!stall),
    .din   (dl_in),
    .dout  (dl_out)
  );

  // Strobes are gated by stall so a frozen line cannot repeat a write or result.
  assign buf_wr_en   = dl_out[CW+1] & dl_out[CW] & !stall;
  assign out_valid   = dl_out[CW+1] & !dl_out[CW] & !stall;
  assign buf_wr_addr = dl_out[CW-1:0];
  assign out_idx     = dl_out[CW-1:0];

endmodule

// File: tb/tb_transform_2d_seq_ctrl.sv
// Scoreboard bench: a LAT=2 and a LAT=0 sequencer, expected strobes queued at launch time.
module tb_transform_2d_seq_ctrl;

  localparam int Far = 32'h3fff_ffff;

  typedef struct {
    int   cyc;
    int   idx;
    logic pass;
  } ev_t;

  logic clk, reset;
  logic a_start, a_stall, b_start, b_stall;
  logic [2:0] a_size, b_size;
  logic a_ready, a_busy, a_done, a_dir, a_src, a_issue, a_wr, a_ov;
  logic b_ready, b_busy, b_done, b_dir, b_src, b_issue, b_wr, b_ov;
  logic [4:0] a_row, a_wa, a_oi, b_row, b_wa, b_oi;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  ev_t q_iss[$];
  ev_t q_wr[$];
  ev_t q_out[$];
  int  q_done[$];

  transform_2d_seq_ctrl #(.MAX_N(32), .LAT(2)) u_dut_a (
    .clk(clk), .reset(reset), .start(a_start), .size_log2(a_size), .stall(a_stall),
    .ready(a_ready), .busy(a_busy), .done(a_done), .direction(a_dir), .src_sel(a_src),
    .row_idx(a_row), .issue(a_issue), .buf_wr_en(a_wr), .buf_wr_addr(a_wa),
    .out_valid(a_ov), .out_idx(a_oi)
  );

  transform_2d_seq_ctrl #(.MAX_N(32), .LAT(0)) u_dut_b (
    .clk(clk), .reset(reset), .start(b_start), .size_log2(b_size), .stall(b_stall),
    .ready(b_ready), .busy(b_busy), .done(b_done), .direction(b_dir), .src_sel(b_src),
    .row_idx(b_row), .issue(b_issue), .buf_wr_en(b_wr), .buf_wr_addr(b_wa),
    .out_valid(b_ov), .out_idx(b_oi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int map_cyc(input int t, input int u, input int s0, input int slen);
    return (t + u < s0) ? t + u : t + u + slen;
  endfunction

  // Expected strobes of one run accepted at edge t; events after cut are not expected.
  task automatic plan_run(input int t, input int n, input int lat, input int s0,
                          input int slen, input int cut);
    int c;
    for (int i = 0; i < n; i++) begin
      c = map_cyc(t, i, s0, slen);
      if (c <= cut) q_iss.push_back('{cyc: c, idx: i, pass: 1'b1});
    end
    for (int i = 0; i < n; i++) begin
      c = map_cyc(t, n + lat + i, s0, slen);
      if (c <= cut) q_iss.push_back('{cyc: c, idx: i, pass: 1'b0});
    end
    for (int i = 0; i < n; i++) begin
      c = map_cyc(t, i + lat, s0, slen);
      if (c <= cut) q_wr.push_back('{cyc: c, idx: i, pass: 1'b1});
      c = map_cyc(t, n + 2 * lat + i, s0, slen);
      if (c <= cut) q_out.push_back('{cyc: c, idx: i, pass: 1'b0});
    end
    c = map_cyc(t, 2 * n + 2 * lat, s0, slen);
    if (c <= cut) q_done.push_back(c);
  endtask

  task automatic observe(input logic iss, input logic [4:0] ridx, input logic dir,
                         input logic src, input logic wr, input logic [4:0] wa,
                         input logic ov, input logic [4:0] oi, input logic dn);
    ev_t e;
    int  d;
    if (iss === 1'b1) begin
      if (q_iss.size() == 0) check_eq("issue_unexpected", cyc, -1);
      else begin
        e = q_iss.pop_front();
        check_eq("issue_cycle", cyc, e.cyc);
        check_eq("issue_row", int'(ridx), e.idx);
        check_eq("issue_direction", int'(dir), int'(e.pass));
        check_eq("issue_src_sel", int'(src), int'(!e.pass));
      end
    end
    if (wr === 1'b1) begin
      if (q_wr.size() == 0) check_eq("buf_wr_unexpected", cyc, -1);
      else begin
        e = q_wr.pop_front();
        check_eq("buf_wr_cycle", cyc, e.cyc);
        check_eq("buf_wr_addr", int'(wa), e.idx);
      end
    end
    if (ov === 1'b1) begin
      if (q_out.size() == 0) check_eq("out_valid_unexpected", cyc, -1);
      else begin
        e = q_out.pop_front();
        check_eq("out_valid_cycle", cyc, e.cyc);
        check_eq("out_idx", int'(oi), e.idx);
      end
    end
    if (dn === 1'b1) begin
      if (q_done.size() == 0) check_eq("done_unexpected", cyc, -1);
      else begin
        d = q_done.pop_front();
        check_eq("done_cycle", cyc, d);
      end
    end
  endtask

  always @(negedge clk) begin
    observe(a_issue, a_row, a_dir, a_src, a_wr, a_wa, a_ov, a_oi, a_done);
    observe(b_issue, b_row, b_dir, b_src, b_wr, b_wa, b_ov, b_oi, b_done);
  end

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic launch(input int inst, input logic [2:0] sz, output int t);
    if (inst == 0) begin
      a_start = 1'b1;
      a_size  = sz;
    end else begin
      b_start = 1'b1;
      b_size  = sz;
    end
    @(posedge clk);
    #1;
    t = cyc;
    a_start = 1'b0;
    b_start = 1'b0;
  endtask

  task automatic run_plain(input int inst, input logic [2:0] sz, input int n, input int lat);
    int t;
    launch(inst, sz, t);
    plan_run(t, n, lat, Far, 0, Far);
    check_eq("busy_in_run", int'(inst == 0 ? a_busy : b_busy), 1);
    wait_until(t + 2 * n + 2 * lat + 1);
    check_eq("ready_after_done", int'(inst == 0 ? a_ready : b_ready), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    int t, t2;
    reset = 1'b1;
    a_start = 1'b0; a_stall = 1'b0; a_size = 3'd0;
    b_start = 1'b0; b_stall = 1'b0; b_size = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", int'(a_ready), 1);
    check_eq("rst_busy", int'(a_busy), 0);
    check_eq("rst_done", int'(a_done), 0);
    check_eq("rst_direction", int'(a_dir), 0);
    check_eq("rst_src_sel", int'(a_src), 0);
    check_eq("rst_row_idx", int'(a_row), 0);
    check_eq("rst_issue", int'(a_issue), 0);
    check_eq("rst_buf_wr_en", int'(a_wr), 0);
    check_eq("rst_buf_wr_addr", int'(a_wa), 0);
    check_eq("rst_out_valid", int'(a_ov), 0);
    check_eq("rst_out_idx", int'(a_oi), 0);
    check_eq("rst_b_ready", int'(b_ready), 1);
    reset = 1'b0;
    wait_until(cyc + 2);

    run_plain(0, 3'd3, 8, 2);
    run_plain(0, 3'd7, 32, 2);
    run_plain(0, 3'd0, 4, 2);

    // Three-cycle stall while H_RUN is on row 5.
    launch(0, 3'd3, t);
    plan_run(t, 8, 2, t + 5, 3, Far);
    wait_until(t + 5);
    a_stall = 1'b1;
    wait_until(t + 6);
    check_eq("stall_row_hold", int'(a_row), 5);
    check_eq("stall_issue", int'(a_issue), 0);
    check_eq("stall_buf_wr", int'(a_wr), 0);
    wait_until(t + 8);
    a_stall = 1'b0;
    wait_until(t + 24);
    check_eq("stall_ready_after", int'(a_ready), 1);

    // start held through a run: the next run starts after exactly one IDLE cycle.
    a_start = 1'b1;
    a_size  = 3'd2;
    @(posedge clk);
    #1;
    t  = cyc;
    t2 = t + 14;
    plan_run(t, 4, 2, Far, 0, Far);
    plan_run(t2, 4, 2, Far, 0, Far);
    wait_until(t2 - 1);
    check_eq("held_idle_gap_ready", int'(a_ready), 1);
    wait_until(t2);
    a_start = 1'b0;
    wait_until(t2 + 13);

    // start pulsed only during DONE is ignored.
    launch(0, 3'd2, t);
    plan_run(t, 4, 2, Far, 0, Far);
    wait_until(t + 12);
    check_eq("pulse_in_done", int'(a_done), 1);
    a_start = 1'b1;
    wait_until(t + 13);
    a_start = 1'b0;
    wait_until(t + 20);
    check_eq("pulse_ignored_ready", int'(a_ready), 1);

    // Reset in V_RUN at row 2 aborts the run.
    launch(0, 3'd3, t);
    plan_run(t, 8, 2, Far, 0, t + 12);
    wait_until(t + 12);
    check_eq("pre_reset_vrow", int'(a_row), 2);
    reset = 1'b1;
    wait_until(t + 13);
    check_eq("abort_ready", int'(a_ready), 1);
    check_eq("abort_busy", int'(a_busy), 0);
    check_eq("abort_src_sel", int'(a_src), 0);
    reset = 1'b0;
    wait_until(t + 40);

    run_plain(1, 3'd2, 4, 0);
    run_plain(1, 3'd5, 32, 0);

    wait_until(cyc + 5);
    check_eq("left_issue", q_iss.size(), 0);
    check_eq("left_buf_wr", q_wr.size(), 0);
    check_eq("left_out_valid", q_out.size(), 0);
    check_eq("left_done", q_done.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
